vga_timing_gen: RTL and testbench

Pixel-clock timing generator that drives the text/tile layer and any other raster consumer. It sequences horizontal and vertical phases (active, front porch, sync, back porch) through explicit state machines. It emits raw pixel coordinates (counting through blanking), active/blank flags, sync pulses and line/frame start strobes. It sits directly upstream of the tile layer, which uses its coordinate, active-area and horizontal-blank outputs.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/vga_timing_gen_if.sv | 40 ++++
 rtl/vga_phase_counter.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and defaults for the VGA raster timing generator (640x480 @ 800x525).
// The optional frame counter is enabled by defining VGA_TIMING_FRAME_CNT_EN.
package vga_timing_pkg;

   localparam int COORD_W = 16;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   typedef struct packed {
      coord_t active;
      coord_t front;
      coord_t sync;
      coord_t back;
   } phase_len_t;

   function automatic phase_t phase_succ(input phase_t p);
      phase_t n;
      n = PH_ACTIVE;
      unique case (p)
         PH_ACTIVE: n = PH_FRONT;
         PH_FRONT:  n = PH_SYNC;
         PH_SYNC:   n = PH_BACK;
         PH_BACK:   n = PH_ACTIVE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the generator (master) and its consumers (slave).
// o_frame_count only exists when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic   i_enable;
   coord_t o_horz_coord;
   coord_t o_vert_coord;
   logic   o_in_active_area;
   logic   o_horz_blank;
   logic   o_vert_blank;
   logic   o_hsync;
   logic   o_vsync;
   logic   o_line_start;
   logic   o_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] o_frame_count;
`endif

   modport master (
      input  i_enable,
      output o_horz_coord, o_vert_coord, o_in_active_area,
      output o_horz_blank, o_vert_blank, o_hsync, o_vsync,
      output o_line_start, o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
      , output o_frame_count
`endif
   );

   modport slave (
      output i_enable,
      input  o_horz_coord, o_vert_coord, o_in_active_area,
      input  o_horz_blank, o_vert_blank, o_hsync, o_vsync,
      input  o_line_start, o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
      , input o_frame_count
`endif
   );

endinterface

// File: rtl/vga_phase_counter.sv
// One raster axis: walks ACTIVE/FRONT/SYNC/BACK and keeps a raw coordinate
// that runs straight through blanking and wraps when BACK ends.
module vga_phase_counter
   import vga_timing_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  phase_len_t len,
   input  logic       advance,
   output coord_t     count,
   output phase_t     next_phase,
   output logic       wrap
);

   phase_t state;
   coord_t phase_cnt;
   coord_t phase_cnt_nxt;
   coord_t count_nxt;
   coord_t cur_len;
   logic   last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PH_ACTIVE;
         phase_cnt <= '0;
         count     <= '0;
      end else begin
         state     <= next_phase;
         phase_cnt <= phase_cnt_nxt;
         count     <= count_nxt;
      end
   end

   always_comb begin
      next_phase    = state;
      phase_cnt_nxt = phase_cnt;
      count_nxt     = count;
      if (advance) begin
         count_nxt = wrap ? '0 : count + coord_t'(1);
         if (last) begin
            next_phase    = phase_succ(state);
            phase_cnt_nxt = '0;
         end else begin
            phase_cnt_nxt = phase_cnt + coord_t'(1);
         end
      end
   end

   // wrap is qualified by advance so the next axis can use it as its own step
   always_comb begin
      cur_len = len.active;
      unique case (state)
         PH_ACTIVE: cur_len = len.active;
         PH_FRONT:  cur_len = len.front;
         PH_SYNC:   cur_len = len.sync;
         PH_BACK:   cur_len = len.back;
      endcase
      last = (phase_cnt == cur_len - coord_t'(1));
      wrap = advance && last && (state == PH_BACK);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator: chains horizontal wrap into vertical advance.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_count output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE         = DEF_H_ACTIVE,
   parameter int H_FRONT          = DEF_H_FRONT,
   parameter int H_SYNC           = DEF_H_SYNC,
   parameter int H_BACK           = DEF_H_BACK,
   parameter int V_ACTIVE         = DEF_V_ACTIVE,
   parameter int V_FRONT          = DEF_V_FRONT,
   parameter int V_SYNC           = DEF_V_SYNC,
   parameter int V_BACK           = DEF_V_BACK,
   parameter int SYNC_ACTIVE_HIGH = 0
)(
   input  logic              i_pix_clk,
   input  logic              i_reset,
   vga_timing_gen_if.master  bus
);

   localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

   localparam phase_len_t H_LEN = '{
      active: coord_t'(H_ACTIVE), front: coord_t'(H_FRONT),
      sync:   coord_t'(H_SYNC),   back:  coord_t'(H_BACK)
   };
   localparam phase_len_t V_LEN = '{
      active: coord_t'(V_ACTIVE), front: coord_t'(V_FRONT),
      sync:   coord_t'(V_SYNC),   back:  coord_t'(V_BACK)
   };

   // running is clear from reset until the first enabled edge, which only
   // publishes (0,0) without stepping the counters
   logic   running;
   logic   advance;
   logic   h_wrap;
   logic   v_wrap;
   coord_t h_count;
   coord_t v_count;
   phase_t h_phase;
   phase_t v_phase;

   assign advance = bus.i_enable & running;

   vga_phase_counter u_horz (
      .clk        (i_pix_clk),
      .rst        (i_reset),
      .len        (H_LEN),
      .advance    (advance),
      .count      (h_count),
      .next_phase (h_phase),
      .wrap       (h_wrap)
   );

   vga_phase_counter u_vert (
      .clk        (i_pix_clk),
      .rst        (i_reset),
      .len        (V_LEN),
      .advance    (h_wrap),
      .count      (v_count),
      .next_phase (v_phase),
      .wrap       (v_wrap)
   );

   assign bus.o_horz_coord = h_count;
   assign bus.o_vert_coord = v_count;

   // flags are registered from the phases the counters move to on this edge,
   // so they line up with the coordinates they describe
   always_ff @(posedge i_pix_clk or posedge i_reset) begin
      if (i_reset) begin
         running              <= 1'b0;
         bus.o_in_active_area <= 1'b0;
         bus.o_horz_blank     <= 1'b1;
         bus.o_vert_blank     <= 1'b1;
         bus.o_hsync          <= ~SYNC_ON;
         bus.o_vsync          <= ~SYNC_ON;
         bus.o_line_start     <= 1'b0;
         bus.o_frame_start    <= 1'b0;
      end else if (bus.i_enable) begin
         running              <= 1'b1;
         bus.o_in_active_area <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
         bus.o_horz_blank     <= (h_phase != PH_ACTIVE);
         bus.o_vert_blank     <= (v_phase != PH_ACTIVE);
         bus.o_hsync          <= (h_phase == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
         bus.o_vsync          <= (v_phase == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
         bus.o_line_start     <= h_wrap | ~running;
         bus.o_frame_start    <= v_wrap | ~running;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt;

   always_ff @(posedge i_pix_clk or posedge i_reset) begin
      if (i_reset)     frame_cnt <= '0;
      else if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
   end

   assign bus.o_frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-geometry DUT plus a tiny-geometry DUT, both
// checked every cycle against a pixel-index reference model plus directed vectors.
module tb_vga_timing_gen;

   localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
   localparam int SVA = 5, SVF = 2, SVS = 2, SVB = 3;
   localparam int FR_S = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
   localparam int FR_D = 800 * 525;
   localparam logic [38:0] RST_V = {16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   always #5 clk = ~clk;

   vga_timing_gen_if bd ();
   vga_timing_gen_if bs ();
   assign bd.i_enable = en;
   assign bs.i_enable = en;

   vga_timing_gen dut_d (.i_pix_clk(clk), .i_reset(rst), .bus(bd));

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
      .SYNC_ACTIVE_HIGH(0)
   ) dut_s (.i_pix_clk(clk), .i_reset(rst), .bus(bs));

   logic [38:0] act_d, act_s;
   assign act_d = {bd.o_horz_coord, bd.o_vert_coord, bd.o_in_active_area, bd.o_horz_blank,
                   bd.o_vert_blank, bd.o_hsync, bd.o_vsync, bd.o_line_start, bd.o_frame_start};
   assign act_s = {bs.o_horz_coord, bs.o_vert_coord, bs.o_in_active_area, bs.o_horz_blank,
                   bs.o_vert_blank, bs.o_hsync, bs.o_vsync, bs.o_line_start, bs.o_frame_start};

   // Reference model: a linear pixel index within the frame; the first enabled
   // edge after reset only starts the raster, later enabled edges step it.
   bit mrun;
   int mp_d, mp_s;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mrun <= 1'b0;
         mp_d <= 0;
         mp_s <= 0;
      end else if (en) begin
         mrun <= 1'b1;
         if (mrun) begin
            mp_d <= (mp_d + 1) % FR_D;
            mp_s <= (mp_s + 1) % FR_S;
         end
      end
   end

   function automatic logic [38:0] pk(input int h, input int v, input bit a, input bit hb,
                                      input bit vb, input bit hs, input bit vs, input bit ls,
                                      input bit fs);
      return {16'(h), 16'(v), a, hb, vb, hs, vs, ls, fs};
   endfunction

   function automatic logic [38:0] expv(input int p, input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf, input int vs,
                                        input bit run);
      int  ht, h, v;
      bit  hsy, vsy;
      if (!run) return RST_V;
      ht  = ha + hf + hs + hb;
      h   = p % ht;
      v   = p / ht;
      hsy = (h >= ha + hf) && (h < ha + hf + hs);
      vsy = (v >= va + vf) && (v < va + vf + vs);
      return pk(h, v, (h < ha) && (v < va), h >= ha, v >= va, !hsy, !vsy, h == 0, p == 0);
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [38:0] got, input logic [38:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
      end
   endtask

   task automatic step(input bit e);
      en = e;
      @(posedge clk);
      #1;
      check("model_dflt",  act_d, expv(mp_d, 640, 16, 96, 48, 480, 10, 2, mrun));
      check("model_small", act_s, expv(mp_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, mrun));
   endtask

   typedef struct packed {
      int          cyc;
      logic [38:0] exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      //         cycles  h    v  act hbl vbl hs vs ls fs
      tbl[0]  = '{0,   pk(0,   0, 0, 1, 1, 1, 1, 0, 0)};
      tbl[1]  = '{1,   pk(0,   0, 1, 0, 0, 1, 1, 1, 1)};
      tbl[2]  = '{1,   pk(1,   0, 1, 0, 0, 1, 1, 0, 0)};
      tbl[3]  = '{638, pk(639, 0, 1, 0, 0, 1, 1, 0, 0)};
      tbl[4]  = '{1,   pk(640, 0, 0, 1, 0, 1, 1, 0, 0)};
      tbl[5]  = '{15,  pk(655, 0, 0, 1, 0, 1, 1, 0, 0)};
      tbl[6]  = '{1,   pk(656, 0, 0, 1, 0, 0, 1, 0, 0)};
      tbl[7]  = '{95,  pk(751, 0, 0, 1, 0, 0, 1, 0, 0)};
      tbl[8]  = '{1,   pk(752, 0, 0, 1, 0, 1, 1, 0, 0)};
      tbl[9]  = '{47,  pk(799, 0, 0, 1, 0, 1, 1, 0, 0)};
      tbl[10] = '{1,   pk(0,   1, 1, 0, 0, 1, 1, 1, 0)};
      tbl[11] = '{800, pk(0,   2, 1, 0, 0, 1, 1, 1, 0)};

      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_small", act_s, RST_V);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < tbl[i].cyc; c++) step(1'b1);
         check($sformatf("vec%0d", i), act_d, tbl[i].exp);
      end

      // asynchronous reset mid-frame, held 3 cycles, then restart from (0,0)
      rst = 1'b1;
      #1;
      check("async_rst_dflt",  act_d, RST_V);
      check("async_rst_small", act_s, RST_V);
      repeat (3) step(1'b1);
      rst = 1'b0;
      step(1'b1);
      check("restart_small", act_s, pk(0, 0, 1, 0, 0, 1, 1, 1, 1));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("fcount_first", {23'd0, bs.o_frame_count}, 39'd0);
`endif
      repeat (FR_S) step(1'b1);
      check("frame_again_small", act_s, pk(0, 0, 1, 0, 0, 1, 1, 1, 1));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("fcount_one", {23'd0, bs.o_frame_count}, 39'd1);
`endif

      // freeze with enable low at (7,3), then resume one pixel later
      repeat (52) step(1'b1);
      check("pre_hold", act_s, pk(7, 3, 1, 0, 0, 1, 1, 0, 0));
      for (int k = 0; k < 10; k++) begin
         step(1'b0);
         check("hold", act_s, pk(7, 3, 1, 0, 0, 1, 1, 0, 0));
      end
      step(1'b1);
      check("resume", act_s, pk(8, 3, 0, 1, 0, 1, 1, 0, 0));

      // strobe stays high while disabled
      repeat (7) step(1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         check("strobe_hold", act_s, pk(0, 4, 1, 0, 0, 1, 1, 1, 0));
      end
      repeat (45) step(1'b1);
      check("vsync_line7", act_s, pk(0, 7, 0, 0, 1, 1, 0, 1, 0));

`ifdef VGA_TIMING_FRAME_CNT_EN
      force dut_s.frame_cnt = 16'hFFFF;
      #1;
      release dut_s.frame_cnt;
      check("fcount_forced", {23'd0, bs.o_frame_count}, {23'd0, 16'hFFFF});
      begin
         int guard;
         guard = 0;
         while (mp_s != 0 && guard < 2 * FR_S) begin
            step(1'b1);
            guard++;
         end
         check("fcount_wrap_reached", {38'd0, mp_s == 0}, 39'd1);
      end
      check("fcount_wrap", {23'd0, bs.o_frame_count}, 39'd0);
`endif

      repeat (2 * FR_S) step(1'b1);

      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1;
            check("rand_rst", act_s, RST_V);
            repeat (2) step(1'b1);
            rst = 1'b0;
         end
         step($urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
